// File: rtl/registers_pkg.sv
// ============================================================================
// Module : registers_pkg
// Brief  : Shared operation and FSM state encodings for the register file.
// Rev    : 1.0 - parametrised register file with INC/DEC/CLEAR
// ============================================================================
`default_nettype none

package registers_pkg;

    // REG_NOP/REG_WRITE keep their legacy encodings; encodings 5..7 are unused.
    typedef enum logic [2:0] {
        REG_NOP   = 3'd0,
        REG_WRITE = 3'd1,
        REG_INC   = 3'd2,
        REG_DEC   = 3'd3,
        REG_CLEAR = 3'd4
    } registers_op_e;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } regfile_state_e;

    localparam int MIN_REGS = 2;
    localparam int MAX_REGS = 16;

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ============================================================================
// Module : regfile_read_port
// Brief  : One combinational read port: range check, R0 masking, write bypass.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_read_port
    import registers_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int NUM_REGS       = 4,
    parameter int ZERO_REG0      = 0,
    parameter int BYPASS         = 0,
    localparam int SEL_WIDTH     = $clog2(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_BUS_WIDTH-1:0] regs,
    input  logic [SEL_WIDTH-1:0]                    sel,
    input  logic                                    wr_fwd_valid,
    input  logic [SEL_WIDTH-1:0]                    wr_sel,
    input  logic [DATA_BUS_WIDTH-1:0]               wr_data,
    output logic [DATA_BUS_WIDTH-1:0]               rd_data
);

    always_comb begin
        rd_data = '0;
        // Matching by loop keeps out-of-range selects from indexing past the array.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_WIDTH'(i) && !(ZERO_REG0 != 0 && i == 0)) begin
                rd_data = regs[i];
            end
        end
        if (BYPASS != 0 && wr_fwd_valid && sel == wr_sel) begin
            rd_data = wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module : register_file
// Brief  : Parametrised GP register file with INC/DEC, carry and clear sweep.
// Rev    : 1.0 - successor of the fixed 4x8 bank
// ============================================================================
`default_nettype none

module register_file
    import registers_pkg::*;
#(
    parameter int DATA_BUS_WIDTH = 8,
    parameter int NUM_REGS       = 4,
    parameter int ZERO_REG0      = 0,
    parameter int BYPASS         = 0,
    localparam int SEL_WIDTH     = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  registers_op_e             op,
    input  logic [SEL_WIDTH-1:0]      reg_in_sel,
    input  logic [SEL_WIDTH-1:0]      reg_1_out_sel,
    input  logic [SEL_WIDTH-1:0]      reg_2_out_sel,
    input  logic [DATA_BUS_WIDTH-1:0] reg_data_in,
    output logic [DATA_BUS_WIDTH-1:0] reg_1_out,
    output logic [DATA_BUS_WIDTH-1:0] reg_2_out,
    output logic                      reg_carry,
    output logic                      busy
);

    logic [NUM_REGS-1:0][DATA_BUS_WIDTH-1:0] regs_q, regs_d;
    logic                                    carry_q, carry_d;
    regfile_state_e                          state_q, state_d;
    logic [SEL_WIDTH-1:0]                    idx_q, idx_d;

    logic                      tgt_valid;
    logic [DATA_BUS_WIDTH-1:0] tgt_value;
    logic [DATA_BUS_WIDTH:0]   inc_sum;
    logic [DATA_BUS_WIDTH:0]   dec_diff;
    logic                      upd_en;
    logic [DATA_BUS_WIDTH-1:0] upd_val;
    logic                      wr_fwd;

    assign busy      = (state_q == RF_CLEAR);
    assign reg_carry = carry_q;

    always_comb begin
        tgt_valid = 1'b0;
        tgt_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_in_sel == SEL_WIDTH'(i) && !(ZERO_REG0 != 0 && i == 0)) begin
                tgt_valid = 1'b1;
                tgt_value = regs_q[i];
            end
        end
    end

    // The extra MSB of each result is the wrap carry / borrow.
    assign inc_sum  = {1'b0, tgt_value} + {{DATA_BUS_WIDTH{1'b0}}, 1'b1};
    assign dec_diff = {1'b0, tgt_value} - {{DATA_BUS_WIDTH{1'b0}}, 1'b1};
    assign wr_fwd   = (op == REG_WRITE) && !busy && tgt_valid;

    always_comb begin
        regs_d  = regs_q;
        carry_d = carry_q;
        state_d = state_q;
        idx_d   = idx_q;
        upd_en  = 1'b0;
        upd_val = reg_data_in;

        case (state_q)
            RF_IDLE: begin
                case (op)
                    REG_WRITE: begin
                        upd_en = tgt_valid;
                    end
                    REG_INC: begin
                        upd_en  = tgt_valid;
                        upd_val = inc_sum[DATA_BUS_WIDTH-1:0];
                        carry_d = tgt_valid & inc_sum[DATA_BUS_WIDTH];
                    end
                    REG_DEC: begin
                        upd_en  = tgt_valid;
                        upd_val = dec_diff[DATA_BUS_WIDTH-1:0];
                        carry_d = tgt_valid & dec_diff[DATA_BUS_WIDTH];
                    end
                    REG_CLEAR: begin
                        idx_d   = '0;
                        state_d = RF_CLEAR;
                    end
                    default: begin
                    end
                endcase
            end
            RF_CLEAR: begin
                carry_d = 1'b0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (idx_q == SEL_WIDTH'(i)) begin
                        regs_d[i] = '0;
                    end
                end
                if (idx_q == SEL_WIDTH'(NUM_REGS - 1)) begin
                    idx_d   = '0;
                    state_d = RF_IDLE;
                end else begin
                    idx_d = idx_q + SEL_WIDTH'(1);
                end
            end
            default: begin
                state_d = RF_IDLE;
            end
        endcase

        for (int i = 0; i < NUM_REGS; i++) begin
            if (upd_en && reg_in_sel == SEL_WIDTH'(i)) begin
                regs_d[i] = upd_val;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            regs_q  <= '0;
            carry_q <= 1'b0;
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            carry_q <= carry_d;
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    regfile_read_port #(
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .ZERO_REG0      (ZERO_REG0),
        .BYPASS         (BYPASS)
    ) u_read_port_1 (
        .regs         (regs_q),
        .sel          (reg_1_out_sel),
        .wr_fwd_valid (wr_fwd),
        .wr_sel       (reg_in_sel),
        .wr_data      (reg_data_in),
        .rd_data      (reg_1_out)
    );

    regfile_read_port #(
        .DATA_BUS_WIDTH (DATA_BUS_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .ZERO_REG0      (ZERO_REG0),
        .BYPASS         (BYPASS)
    ) u_read_port_2 (
        .regs         (regs_q),
        .sel          (reg_2_out_sel),
        .wr_fwd_valid (wr_fwd),
        .wr_sel       (reg_in_sel),
        .wr_data      (reg_data_in),
        .rd_data      (reg_2_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module : tb_register_file
// Brief  : Directed bench: default 4x8 bank and a 5-register R0-zero/bypass bank.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;
    import registers_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Bank A: defaults (4 regs, no R0 masking, no bypass)
    registers_op_e op_a;
    logic [1:0]    in_a, s1_a, s2_a;
    logic [7:0]    din_a, o1_a, o2_a;
    logic          carry_a, busy_a;

    register_file u_dut_a (
        .clock         (clk),
        .reset         (rst_n),
        .op            (op_a),
        .reg_in_sel    (in_a),
        .reg_1_out_sel (s1_a),
        .reg_2_out_sel (s2_a),
        .reg_data_in   (din_a),
        .reg_1_out     (o1_a),
        .reg_2_out     (o2_a),
        .reg_carry     (carry_a),
        .busy          (busy_a)
    );

    // Bank B: 5 regs, hardwired-zero R0, write bypass
    registers_op_e op_b;
    logic [2:0]    in_b, s1_b, s2_b;
    logic [7:0]    din_b, o1_b, o2_b;
    logic          carry_b, busy_b;

    register_file #(
        .DATA_BUS_WIDTH (8),
        .NUM_REGS       (5),
        .ZERO_REG0      (1),
        .BYPASS         (1)
    ) u_dut_b (
        .clock         (clk),
        .reset         (rst_n),
        .op            (op_b),
        .reg_in_sel    (in_b),
        .reg_1_out_sel (s1_b),
        .reg_2_out_sel (s2_b),
        .reg_data_in   (din_b),
        .reg_1_out     (o1_b),
        .reg_2_out     (o2_b),
        .reg_carry     (carry_b),
        .busy          (busy_b)
    );

    typedef struct {
        registers_op_e op;
        logic [1:0]    in_sel;
        logic [1:0]    s1;
        logic [1:0]    s2;
        logic [7:0]    d;
        logic [7:0]    e1;
        logic [7:0]    e2;
        logic          ec;
        logic          eb;
    } vec_t;

    vec_t       vecs [16];
    logic [7:0] exp_b [5];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input registers_op_e op, input logic [1:0] in_sel,
                           input logic [1:0] s1, input logic [1:0] s2, input logic [7:0] d);
        op_a = op; in_a = in_sel; s1_a = s1; s2_a = s2; din_a = d;
    endtask

    task automatic drive_b(input registers_op_e op, input logic [2:0] in_sel,
                           input logic [2:0] s1, input logic [2:0] s2, input logic [7:0] d);
        op_b = op; in_b = in_sel; s1_b = s1; s2_b = s2; din_b = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        // Expected reads reflect state before the vector's own clock edge.
        vecs[0]  = '{REG_NOP,   2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{REG_NOP,   2'd0, 2'd2, 2'd3, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{REG_WRITE, 2'd2, 2'd2, 2'd3, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{REG_WRITE, 2'd3, 2'd2, 2'd3, 8'h3C, 8'hA5, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{REG_NOP,   2'd0, 2'd2, 2'd3, 8'h00, 8'hA5, 8'h3C, 1'b0, 1'b0};
        vecs[5]  = '{REG_NOP,   2'd0, 2'd0, 2'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6]  = '{REG_WRITE, 2'd1, 2'd1, 2'd0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[7]  = '{REG_INC,   2'd1, 2'd1, 2'd2, 8'h00, 8'hFF, 8'hA5, 1'b0, 1'b0};
        vecs[8]  = '{REG_DEC,   2'd1, 2'd1, 2'd2, 8'h00, 8'h00, 8'hA5, 1'b1, 1'b0};
        vecs[9]  = '{REG_DEC,   2'd1, 2'd1, 2'd3, 8'h00, 8'hFF, 8'h3C, 1'b1, 1'b0};
        vecs[10] = '{REG_NOP,   2'd0, 2'd1, 2'd3, 8'h00, 8'hFE, 8'h3C, 1'b0, 1'b0};
        vecs[11] = '{REG_INC,   2'd2, 2'd1, 2'd2, 8'h00, 8'hFE, 8'hA5, 1'b0, 1'b0};
        vecs[12] = '{registers_op_e'(3'd7), 2'd2, 2'd2, 2'd1, 8'h55, 8'hA6, 8'hFE, 1'b0, 1'b0};
        vecs[13] = '{REG_WRITE, 2'd0, 2'd0, 2'd2, 8'h77, 8'h00, 8'hA6, 1'b0, 1'b0};
        vecs[14] = '{REG_DEC,   2'd0, 2'd0, 2'd3, 8'h00, 8'h77, 8'h3C, 1'b0, 1'b0};
        vecs[15] = '{REG_NOP,   2'd0, 2'd0, 2'd1, 8'h00, 8'h76, 8'hFE, 1'b0, 1'b0};
        exp_b[0] = 8'h00; exp_b[1] = 8'h21; exp_b[2] = 8'h22; exp_b[3] = 8'h23; exp_b[4] = 8'hFF;

        rst_n = 1'b0;
        drive_a(REG_NOP, 2'd0, 2'd0, 2'd0, 8'h00);
        drive_b(REG_NOP, 3'd0, 3'd0, 3'd0, 8'h00);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Bank A table: write/read, INC/DEC wrap and carry, unused op, no bypass
        for (int i = 0; i < 16; i++) begin
            drive_a(vecs[i].op, vecs[i].in_sel, vecs[i].s1, vecs[i].s2, vecs[i].d);
            #1;
            check($sformatf("vec%0d_rd1", i), 16'(o1_a), 16'(vecs[i].e1));
            check($sformatf("vec%0d_rd2", i), 16'(o2_a), 16'(vecs[i].e2));
            check($sformatf("vec%0d_carry", i), 16'(carry_a), 16'(vecs[i].ec));
            check($sformatf("vec%0d_busy", i), 16'(busy_a), 16'(vecs[i].eb));
            cyc();
        end

        // Bank A clear sweep: all FF, carry set, then REG_CLEAR
        for (int r = 0; r < 4; r++) begin
            drive_a(REG_WRITE, 2'(r), 2'd0, 2'd0, 8'hFF);
            cyc();
        end
        drive_a(REG_INC, 2'd0, 2'd0, 2'd0, 8'h00);
        cyc();
        drive_a(REG_WRITE, 2'd0, 2'd0, 2'd0, 8'hFF);
        cyc();
        drive_a(REG_CLEAR, 2'd0, 2'd0, 2'd1, 8'h00);
        #1;
        check("clr_busy_before", 16'(busy_a), 16'd0);
        check("clr_carry_before", 16'(carry_a), 16'd1);
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k == 1)      drive_a(REG_WRITE, 2'd0, 2'(k), 2'(k - 1), 8'h12);
            else if (k == 2) drive_a(REG_CLEAR, 2'd0, 2'(k), 2'(k - 1), 8'h00);
            else             drive_a(REG_NOP,   2'd0, 2'(k), 2'(k - 1), 8'h00);
            #1;
            check($sformatf("clr%0d_busy", k), 16'(busy_a), 16'd1);
            check($sformatf("clr%0d_pending", k), 16'(o1_a), 16'hFF);
            check($sformatf("clr%0d_swept", k), 16'(o2_a), (k == 0) ? 16'hFF : 16'h00);
            check($sformatf("clr%0d_carry", k), 16'(carry_a), (k == 0) ? 16'd1 : 16'd0);
            cyc();
        end
        drive_a(REG_WRITE, 2'd2, 2'd3, 2'd0, 8'h34);
        #1;
        check("clr_done_busy", 16'(busy_a), 16'd0);
        check("clr_done_r3", 16'(o1_a), 16'h00);
        check("clr_done_r0", 16'(o2_a), 16'h00);
        cyc();
        drive_a(REG_NOP, 2'd0, 2'd2, 2'd1, 8'h00);
        #1;
        check("post_clr_write_r2", 16'(o1_a), 16'h34);
        check("post_clr_r1", 16'(o2_a), 16'h00);
        check("post_clr_busy", 16'(busy_a), 16'd0);
        cyc();

        // Bank A: reset in the middle of a sweep
        drive_a(REG_WRITE, 2'd1, 2'd0, 2'd0, 8'h99);
        cyc();
        drive_a(REG_WRITE, 2'd3, 2'd0, 2'd0, 8'h88);
        cyc();
        drive_a(REG_CLEAR, 2'd0, 2'd0, 2'd0, 8'h00);
        cyc();
        drive_a(REG_NOP, 2'd0, 2'd3, 2'd1, 8'h00);
        #1;
        check("mid_busy", 16'(busy_a), 16'd1);
        check("mid_r3", 16'(o1_a), 16'h88);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        drive_a(REG_WRITE, 2'd3, 2'd1, 2'd3, 8'h42);
        #1;
        check("rst_busy", 16'(busy_a), 16'd0);
        check("rst_r1", 16'(o1_a), 16'h00);
        check("rst_r3", 16'(o2_a), 16'h00);
        check("rst_carry", 16'(carry_a), 16'd0);
        cyc();
        drive_a(REG_NOP, 2'd0, 2'd3, 2'd2, 8'h00);
        #1;
        check("rst_write_r3", 16'(o1_a), 16'h42);
        check("rst_r2", 16'(o2_a), 16'h00);
        cyc();

        // Bank B: bypass, hardwired R0, out-of-range selects
        drive_b(REG_WRITE, 3'd1, 3'd1, 3'd2, 8'h21);
        #1;
        check("b_byp_r1", 16'(o1_b), 16'h21);
        check("b_r2_old", 16'(o2_b), 16'h00);
        cyc();
        drive_b(REG_WRITE, 3'd2, 3'd2, 3'd1, 8'h22);
        #1;
        check("b_byp_r2", 16'(o1_b), 16'h22);
        check("b_r1", 16'(o2_b), 16'h21);
        cyc();
        drive_b(REG_WRITE, 3'd3, 3'd3, 3'd4, 8'h23);
        #1;
        check("b_byp_r3", 16'(o1_b), 16'h23);
        cyc();
        drive_b(REG_WRITE, 3'd4, 3'd4, 3'd3, 8'hFF);
        #1;
        check("b_byp_r4", 16'(o1_b), 16'hFF);
        check("b_r3", 16'(o2_b), 16'h23);
        cyc();
        drive_b(REG_WRITE, 3'd0, 3'd0, 3'd7, 8'h11);
        #1;
        check("b_r0_no_byp", 16'(o1_b), 16'h00);
        check("b_sel7", 16'(o2_b), 16'h00);
        cyc();
        drive_b(REG_WRITE, 3'd7, 3'd7, 3'd5, 8'h77);
        #1;
        check("b_sel7_no_byp", 16'(o1_b), 16'h00);
        check("b_sel5", 16'(o2_b), 16'h00);
        cyc();
        for (int r = 0; r < 5; r++) begin
            drive_b(REG_NOP, 3'd0, 3'(r), 3'(5 + (r % 3)), 8'h00);
            #1;
            check($sformatf("b_hold_r%0d", r), 16'(o1_b), 16'(exp_b[r]));
            check($sformatf("b_oor_%0d", r), 16'(o2_b), 16'h00);
            cyc();
        end

        // Bank B: INC/DEC never bypassed; invalid targets clear carry
        drive_b(REG_INC, 3'd4, 3'd4, 3'd0, 8'h00);
        #1;
        check("b_inc_no_byp", 16'(o1_b), 16'hFF);
        check("b_carry0", 16'(carry_b), 16'd0);
        cyc();
        drive_b(REG_INC, 3'd0, 3'd4, 3'd0, 8'h00);
        #1;
        check("b_inc_wrap", 16'(o1_b), 16'h00);
        check("b_inc_carry", 16'(carry_b), 16'd1);
        cyc();
        drive_b(REG_DEC, 3'd4, 3'd0, 3'd4, 8'h00);
        #1;
        check("b_inc_r0_val", 16'(o1_b), 16'h00);
        check("b_inc_r0_carry", 16'(carry_b), 16'd0);
        cyc();
        drive_b(REG_DEC, 3'd6, 3'd4, 3'd0, 8'h00);
        #1;
        check("b_dec_wrap", 16'(o1_b), 16'hFF);
        check("b_dec_carry", 16'(carry_b), 16'd1);
        cyc();
        drive_b(REG_CLEAR, 3'd0, 3'd4, 3'd0, 8'h00);
        #1;
        check("b_oor_carry", 16'(carry_b), 16'd0);
        check("b_r4_kept", 16'(o1_b), 16'hFF);
        cyc();

        // Bank B sweep: no bypass while busy, busy lasts exactly NUM_REGS cycles
        begin
            int n;
            drive_b(REG_WRITE, 3'd2, 3'd2, 3'd1, 8'h5A);
            #1;
            check("b_busy_no_byp", 16'(o1_b), 16'h22);
            n = 0;
            for (int t = 0; t < 20 && busy_b; t++) begin
                n++;
                cyc();
                drive_b(REG_NOP, 3'd0, 3'd2, 3'd1, 8'h00);
                #1;
            end
            check("b_busy_cycles", 16'(n), 16'd5);
        end
        drive_b(REG_NOP, 3'd0, 3'd2, 3'd4, 8'h00);
        #1;
        check("b_clr_r2", 16'(o1_b), 16'h00);
        check("b_clr_r4", 16'(o2_b), 16'h00);
        check("b_clr_busy", 16'(busy_b), 16'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
